// File: rtl/power_pkg.sv
// power_pkg: shared power-state types, configuration record and wake-delay default
package power_pkg;
  localparam int unsigned WAKE_DELAY_DEFAULT = 16;
  typedef enum logic [2:0] {
    ACTIVE           = 3'd0,
    IDLE             = 3'd1,
    SLEEP            = 3'd2,
    DEEP_SLEEP       = 3'd3,
    THERMAL_THROTTLE = 3'd4
  } power_state_t;
  typedef struct packed {
    logic [31:0] DEFAULT_IDLE_TIMEOUT;
    logic [31:0] DEFAULT_SLEEP_TIMEOUT;
    logic        power_gating_en;
    logic        aggressive_gating;
    logic        cache_gating_en;
    logic        retention_mode;
  } power_config_t;
endpackage

// File: rtl/power_state_ctrl.sv
// power_state_ctrl: idle/sleep/deep-sleep/thermal power FSM with quiesce handshake and timed wake restore
module power_state_ctrl
  import power_pkg::*;
#(
  parameter int unsigned WAKE_DELAY = WAKE_DELAY_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  power_config_t cfg_i,
  input  logic          core_active_i,
  input  logic          wake_i,
  input  logic          thermal_alert_i,
  input  logic          quiesce_ack_i,
  output logic          quiesce_req_o,
  output power_state_t  power_state_o,
  output logic          clk_gate_en_o,
  output logic          cache_gate_en_o,
  output logic          retention_en_o,
  output logic          pwr_gate_en_o,
  output logic          throttle_o,
  output logic          state_change_o
);
  power_state_t nxt;
  logic [31:0] cnt, cnt_n;
  logic [7:0] wcnt, wcnt_n;
  logic rest, rest_n, qreq_n, go, hot, idle_hit, sleep_hit, slp_n;
  always_comb begin
    go = core_active_i | wake_i;
    hot = thermal_alert_i & (power_state_o == ACTIVE || power_state_o == IDLE || power_state_o == SLEEP);
    idle_hit = cfg_i.DEFAULT_IDLE_TIMEOUT != '0 && cnt >= cfg_i.DEFAULT_IDLE_TIMEOUT;
    sleep_hit = cfg_i.DEFAULT_SLEEP_TIMEOUT != '0 && cnt >= cfg_i.DEFAULT_SLEEP_TIMEOUT;
    nxt = power_state_o;
    rest_n = rest;
    wcnt_n = wcnt;
    qreq_n = 1'b0;
    if (hot) nxt = THERMAL_THROTTLE;
    else case (power_state_o)
      ACTIVE: nxt = (!go && idle_hit) ? IDLE : ACTIVE;
      IDLE: begin
        if (go) nxt = ACTIVE;
        else if (quiesce_req_o && quiesce_ack_i) nxt = SLEEP;
        else qreq_n = quiesce_req_o | sleep_hit;
      end
      SLEEP: nxt = go ? ACTIVE : (cfg_i.power_gating_en && sleep_hit) ? DEEP_SLEEP : SLEEP;
      DEEP_SLEEP: begin
        if (rest) begin
          nxt = (wcnt == 8'd0) ? ACTIVE : DEEP_SLEEP;
          rest_n = wcnt != 8'd0;
          wcnt_n = (wcnt == 8'd0) ? 8'd0 : wcnt - 8'd1;
        end else if (go) begin
          rest_n = 1'b1;
          wcnt_n = 8'(WAKE_DELAY - 1);
        end
      end
      THERMAL_THROTTLE: nxt = thermal_alert_i ? THERMAL_THROTTLE : ACTIVE;
      default: nxt = ACTIVE;
    endcase
    cnt_n = (go || nxt != power_state_o) ? '0 : (cnt == '1) ? cnt : cnt + 32'd1;
    slp_n = nxt == SLEEP || nxt == DEEP_SLEEP;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      power_state_o <= ACTIVE;
      cnt <= '0;
      wcnt <= '0;
      rest <= 1'b0;
      quiesce_req_o <= 1'b0;
      state_change_o <= 1'b0;
      clk_gate_en_o <= 1'b0;
      cache_gate_en_o <= 1'b0;
      retention_en_o <= 1'b0;
      pwr_gate_en_o <= 1'b0;
      throttle_o <= 1'b0;
    end else begin
      power_state_o <= nxt;
      cnt <= cnt_n;
      wcnt <= wcnt_n;
      rest <= rest_n;
      quiesce_req_o <= qreq_n;
      state_change_o <= nxt != power_state_o;
      clk_gate_en_o <= (nxt == IDLE) ? cfg_i.aggressive_gating : slp_n;
      cache_gate_en_o <= slp_n & cfg_i.cache_gating_en;
      retention_en_o <= rest_n ? retention_en_o : slp_n & cfg_i.retention_mode;
      pwr_gate_en_o <= nxt == DEEP_SLEEP && !rest_n;
      throttle_o <= nxt == THERMAL_THROTTLE;
    end
  end
endmodule

// File: tb/tb_power_state_ctrl.sv
// tb_power_state_ctrl: scoreboard bench timing each power transition against hand-derived cycle offsets
module tb_power_state_ctrl;
  import power_pkg::*;
  localparam int S_ST = 0, S_Q = 1, S_CLK = 2, S_CACHE = 3, S_RET = 4, S_PWR = 5, S_THR = 6, S_CHG = 7;
  typedef struct {
    int at;
    int sel;
    logic [31:0] val;
    string tag;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  power_config_t cfg = '0;
  logic core_active = 1'b0, wake = 1'b0, thermal = 1'b0, ack = 1'b0;
  logic quiesce_req, clk_gate, cache_gate, retention, pwr_gate, throttle, state_change;
  power_state_t power_state;
  int cyc = 0, base = 0, total = 0, bad = 0;
  exp_t q[$];
  exp_t e;
  power_state_ctrl #(.WAKE_DELAY(16)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_i(cfg), .core_active_i(core_active), .wake_i(wake),
    .thermal_alert_i(thermal), .quiesce_ack_i(ack), .quiesce_req_o(quiesce_req),
    .power_state_o(power_state), .clk_gate_en_o(clk_gate), .cache_gate_en_o(cache_gate),
    .retention_en_o(retention), .pwr_gate_en_o(pwr_gate), .throttle_o(throttle),
    .state_change_o(state_change)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] get(int sel);
    case (sel)
      S_ST: get = 32'(power_state);
      S_Q: get = 32'(quiesce_req);
      S_CLK: get = 32'(clk_gate);
      S_CACHE: get = 32'(cache_gate);
      S_RET: get = 32'(retention);
      S_PWR: get = 32'(pwr_gate);
      S_THR: get = 32'(throttle);
      default: get = 32'(state_change);
    endcase
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  task automatic push(int rel, int sel, logic [31:0] val, string tag);
    exp_t n;
    int i = 0;
    n.at = base + rel;
    n.sel = sel;
    n.val = val;
    n.tag = tag;
    while (i < q.size() && q[i].at <= n.at) i++;
    q.insert(i, n);
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset(logic [31:0] idle_to, logic [31:0] sleep_to, logic [3:0] flags);
    rst = 1'b1;
    core_active = 1'b0;
    wake = 1'b0;
    thermal = 1'b0;
    ack = 1'b0;
    cfg = '{idle_to, sleep_to, flags[3], flags[2], flags[1], flags[0]};
    step(2);
    for (int s = 0; s < 8; s++) chk($sformatf("reset_sel%0d", s), get(s), 32'd0);
    rst = 1'b0;
    base = cyc;
  endtask
  always @(negedge clk)
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      chk(e.tag, get(e.sel), e.val);
    end
  initial begin
    do_reset(32'd10, 32'd5, 4'b1111);
    push(10, S_ST, ACTIVE, "a_pre_idle");
    push(10, S_CHG, 0, "a_chg_pre");
    push(11, S_ST, IDLE, "a_idle");
    push(11, S_CHG, 1, "a_chg_idle");
    push(11, S_CLK, 1, "a_aggr_gate");
    push(12, S_CHG, 0, "a_chg_once");
    push(16, S_Q, 0, "a_qreq_early");
    push(17, S_Q, 1, "a_qreq_c1");
    push(19, S_Q, 1, "a_qreq_c3");
    push(19, S_ST, IDLE, "a_still_idle");
    push(20, S_ST, SLEEP, "a_sleep");
    push(20, S_Q, 0, "a_qreq_drop");
    push(20, S_CLK, 1, "a_sleep_clk");
    push(20, S_CACHE, 1, "a_sleep_cache");
    push(20, S_RET, 1, "a_sleep_ret");
    push(25, S_ST, SLEEP, "a_pre_deep");
    push(26, S_ST, DEEP_SLEEP, "a_deep");
    push(26, S_PWR, 1, "a_deep_pwr");
    push(28, S_PWR, 0, "a_wake_pwr");
    push(28, S_RET, 1, "a_restore_ret");
    push(32, S_ST, DEEP_SLEEP, "a_restore_noalert");
    push(32, S_THR, 0, "a_restore_nothr");
    push(43, S_ST, DEEP_SLEEP, "a_restore_end");
    push(43, S_RET, 1, "a_ret_hold");
    push(44, S_ST, ACTIVE, "a_woke");
    push(44, S_RET, 0, "a_ret_clear");
    push(44, S_CLK, 0, "a_woke_clk");
    push(44, S_CHG, 1, "a_woke_chg");
    step(19);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(7);
    wake = 1'b1;
    step(1);
    wake = 1'b0;
    step(2);
    thermal = 1'b1;
    wake = 1'b1;
    step(3);
    thermal = 1'b0;
    wake = 1'b0;
    step(12);
    do_reset(32'd2, 32'd3, 4'b0000);
    ack = 1'b1;
    push(7, S_Q, 1, "b_qreq");
    push(7, S_CLK, 0, "b_idle_nogate");
    push(8, S_ST, SLEEP, "b_sleep");
    push(8, S_CACHE, 0, "b_nocache");
    push(8, S_RET, 0, "b_noret");
    push(10, S_ST, THERMAL_THROTTLE, "b_thermal");
    push(10, S_THR, 1, "b_throttle");
    push(10, S_CLK, 0, "b_thr_clk");
    push(12, S_ST, THERMAL_THROTTLE, "b_thr_hold");
    push(13, S_ST, ACTIVE, "b_cool");
    push(13, S_THR, 0, "b_thr_off");
    step(9);
    thermal = 1'b1;
    step(3);
    thermal = 1'b0;
    step(2);
    do_reset(32'd2, 32'd3, 4'b1110);
    push(8, S_Q, 1, "c_qreq_pend");
    push(9, S_ST, ACTIVE, "c_wake_active");
    push(9, S_Q, 0, "c_wake_qdrop");
    push(12, S_ST, IDLE, "c_idle2");
    push(17, S_ST, SLEEP, "c_sleep2");
    push(21, S_ST, DEEP_SLEEP, "c_deep");
    push(21, S_RET, 0, "c_deep_noret");
    push(24, S_ST, DEEP_SLEEP, "c_deep_alert");
    push(24, S_THR, 0, "c_deep_nothr");
    push(27, S_PWR, 0, "c_restore_pwr");
    push(31, S_ST, ACTIVE, "c_rst_state");
    push(31, S_PWR, 0, "c_rst_pwr");
    push(31, S_CLK, 0, "c_rst_clk");
    push(31, S_CACHE, 0, "c_rst_cache");
    push(31, S_CHG, 0, "c_rst_chg");
    push(32, S_CHG, 0, "c_no_residual");
    push(32, S_ST, ACTIVE, "c_rst_hold");
    step(8);
    wake = 1'b1;
    step(1);
    wake = 1'b0;
    step(3);
    ack = 1'b1;
    step(10);
    thermal = 1'b1;
    step(3);
    thermal = 1'b0;
    step(1);
    wake = 1'b1;
    step(1);
    wake = 1'b0;
    step(3);
    rst = 1'b1;
    step(2);
    do_reset(32'd0, 32'd0, 4'b0000);
    push(500, S_ST, ACTIVE, "d_stay_500");
    push(1000, S_ST, ACTIVE, "d_stay_1000");
    push(1000, S_CHG, 0, "d_no_chg");
    push(1001, S_ST, IDLE, "d_live_cfg");
    push(1001, S_CHG, 1, "d_live_chg");
    step(1000);
    cfg.DEFAULT_IDLE_TIMEOUT = 32'd5;
    step(2);
    if (q.size() != 0) chk("leftover_expectations", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/power_state_ctrl.md
POWER_STATE_CTRL -- requirements
Module: power_state_ctrl

Interface
REQ-001 Parameter WAKE_DELAY, default 16, number of cycles from power-gate release to ACTIVE on deep-sleep wake (range 1..255).
REQ-002 clk_i  input  1  core clock; single clock domain.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 cfg_i  input  power_config_t (68)  live power configuration; sampled every cycle.
REQ-005 core_active_i  input  1  core activity indication; high = busy.
REQ-006 wake_i  input  1  wake event (interrupt/debug), level.
REQ-007 thermal_alert_i  input  1  over-temperature alert, level.
REQ-008 quiesce_ack_i  input  1  core acknowledges quiesce request.
REQ-009 quiesce_req_o  output  1  request core to drain and stop.
REQ-010 power_state_o  output  power_state_t (3)  current state.
REQ-011 clk_gate_en_o, cache_gate_en_o, retention_en_o, pwr_gate_en_o, throttle_o  output  1 each  power control enables.
REQ-012 state_change_o  output  1  one-cycle pulse on the cycle after any power_state_o change.

Function
REQ-013 FSM states are the power_state_t values ACTIVE, IDLE, SLEEP, DEEP_SLEEP, THERMAL_THROTTLE, held in a registered state.
REQ-014 A 32-bit saturating idle counter shall increment each cycle that core_active_i=0 and wake_i=0; it shall clear on activity, wake, or any state change.
REQ-015 ACTIVE->IDLE shall occur when counter >= cfg_i.DEFAULT_IDLE_TIMEOUT; timeout 0 disables the transition.
REQ-016 In IDLE, when counter >= cfg_i.DEFAULT_SLEEP_TIMEOUT (0 = disabled), quiesce_req_o shall assert and hold until quiesce_ack_i is sampled high; SLEEP is entered the following cycle and quiesce_req_o drops.
REQ-017 SLEEP->DEEP_SLEEP shall occur when cfg_i.power_gating_en=1 and counter >= DEFAULT_SLEEP_TIMEOUT (nonzero).
REQ-018 From IDLE or SLEEP, core_active_i=1 or wake_i=1 shall return to ACTIVE the next cycle; a pending quiesce_req_o shall drop the same cycle.
REQ-019 From DEEP_SLEEP, wake_i=1 or core_active_i=1 shall deassert pwr_gate_en_o next cycle, start a wake counter, and enter ACTIVE exactly WAKE_DELAY cycles later; further wakes during restore are ignored.
REQ-020 thermal_alert_i=1 in ACTIVE, IDLE or SLEEP shall enter THERMAL_THROTTLE next cycle; it is ignored in DEEP_SLEEP and during deep-sleep restore.
REQ-021 THERMAL_THROTTLE->ACTIVE shall occur the cycle after thermal_alert_i is sampled low.
REQ-022 Priority per cycle: thermal > wake/activity > timeout.
REQ-023 Output decode (registered from next state): ACTIVE all enables 0; IDLE clk_gate_en_o=cfg.aggressive_gating; SLEEP clk_gate_en_o=1, cache_gate_en_o=cfg.cache_gating_en, retention_en_o=cfg.retention_mode; DEEP_SLEEP as SLEEP plus pwr_gate_en_o=1; THERMAL_THROTTLE throttle_o=1 only.
REQ-024 retention_en_o shall remain high through the deep-sleep restore window and clear on entry to ACTIVE.
REQ-025 Timeout comparisons shall use live cfg_i values; lowering a timeout below the current count triggers transition next cycle.

Reset
REQ-026 On rst_i=1 at a clock edge: state ACTIVE, counters 0, all outputs 0 including quiesce_req_o and state_change_o.
REQ-027 Reset asserted mid-handshake or mid-restore shall abort immediately to the reset values with no residual pulse.

Structure
REQ-028 power_state_t, power_config_t and a WAKE_DELAY default constant shall reside in power_pkg; no new package.
REQ-029 Single module; no sub-module required; wake counter 8 bits.

Verification
REQ-030 IDLE_TIMEOUT=10, core_active_i=0 from reset -> power_state_o=IDLE 11 cycles after reset release, state_change_o pulses once.
REQ-031 IDLE, SLEEP_TIMEOUT=5, ack delayed 3 cycles -> quiesce_req_o high 3 cycles, SLEEP next cycle, clk_gate_en_o=1.
REQ-032 power_gating_en=1, DEEP_SLEEP, wake_i pulse, WAKE_DELAY=16 -> pwr_gate_en_o=0 next cycle, ACTIVE 16 cycles later, retention_en_o clears then.
REQ-033 thermal_alert_i in SLEEP -> THERMAL_THROTTLE, throttle_o=1; alert low -> ACTIVE next cycle; alert in DEEP_SLEEP -> no change.
REQ-034 wake_i while quiesce_req_o pending -> req drops, ACTIVE next cycle; rst_i during restore -> all outputs 0 next cycle.
REQ-035 IDLE_TIMEOUT=0 with 1000 idle cycles -> remains ACTIVE.
